// File: rtl/random_victim_sel.sv
// rtl/random_victim_sel.sv - victim way selector: invalid-first, then random unlocked way, held until fill
module random_victim_sel #(
  parameter int NUMWAYS   = 4,
  parameter int LFSRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushStage,
  input  logic                 CacheEn,
  input  logic                 AllocReq,
  input  logic [NUMWAYS-1:0]   ValidWay,
  input  logic [NUMWAYS-1:0]   LockWay,
  input  logic [LFSRWIDTH-1:0] RandIn,
  input  logic                 FillDone,
  output logic [NUMWAYS-1:0]   VictimWay,
  output logic                 VictimValid,
  output logic                 NoVictim,
  output logic                 LFSRAdvance
);

  localparam int IDXW = $clog2(NUMWAYS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_next;
  logic               from_random, from_random_next;
  logic [NUMWAYS-1:0] way_next;
  logic               valid_next, no_victim_next, advance_next;

  logic [NUMWAYS-1:0] free_way;
  logic [NUMWAYS-1:0] pick_way;
  logic               pick_found;
  logic               pick_random;
  logic [IDXW-1:0]    start_idx;
  logic [IDXW-1:0]    scan_idx;

  // Candidate victim: lowest invalid unlocked way, else first unlocked way scanning up from a random start.
  // The modulo by a power-of-two way count keeps only the low index bits of RandIn; the scan index wraps
  // naturally at IDXW bits.
  always_comb begin
    free_way    = ~ValidWay & ~LockWay;
    pick_way    = '0;
    pick_found  = 1'b0;
    pick_random = 1'b0;
    start_idx   = IDXW'(RandIn % LFSRWIDTH'(NUMWAYS));
    scan_idx    = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (!pick_found && free_way[i]) begin
        pick_way[i] = 1'b1;
        pick_found  = 1'b1;
      end
    end
    if (!pick_found) begin
      for (int k = 0; k < NUMWAYS; k++) begin
        scan_idx = start_idx + IDXW'(k);
        if (!pick_found && !LockWay[scan_idx]) begin
          pick_way[scan_idx] = 1'b1;
          pick_found         = 1'b1;
          pick_random        = 1'b1;
        end
      end
    end
  end

  // Next-state and registered-output values; leaving HOLD always clears the held victim.
  always_comb begin
    state_next       = state;
    way_next         = VictimWay;
    valid_next       = VictimValid;
    no_victim_next   = NoVictim;
    from_random_next = from_random;
    advance_next     = 1'b0;
    case (state)
      IDLE: begin
        if (AllocReq && CacheEn && !FlushStage) begin
          state_next       = HOLD;
          way_next         = pick_way;
          valid_next       = 1'b1;
          no_victim_next   = !pick_found;
          from_random_next = pick_random;
        end
      end
      HOLD: begin
        if (FlushStage || FillDone) begin
          state_next       = IDLE;
          way_next         = '0;
          valid_next       = 1'b0;
          no_victim_next   = 1'b0;
          from_random_next = 1'b0;
          advance_next     = FillDone && !FlushStage && from_random;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      VictimWay   <= '0;
      VictimValid <= 1'b0;
      NoVictim    <= 1'b0;
      from_random <= 1'b0;
      LFSRAdvance <= 1'b0;
    end else begin
      state       <= state_next;
      VictimWay   <= way_next;
      VictimValid <= valid_next;
      NoVictim    <= no_victim_next;
      from_random <= from_random_next;
      LFSRAdvance <= advance_next;
    end
  end

endmodule

// File: tb/tb_random_victim_sel.sv
// tb/tb_random_victim_sel.sv - scoreboard bench for random_victim_sel
module tb_random_victim_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       FlushStage, CacheEn, AllocReq, FillDone;
  logic [3:0] ValidWay, LockWay;
  logic [7:0] RandIn;
  logic [3:0] VictimWay;
  logic       VictimValid, NoVictim, LFSRAdvance;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];   // {NoVictim, VictimWay} expected at each allocation
  logic       rel_q[$];   // expected LFSRAdvance at each HOLD exit
  logic       sb_on = 1'b1;

  random_victim_sel #(.NUMWAYS(4), .LFSRWIDTH(8)) dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .CacheEn(CacheEn),
    .AllocReq(AllocReq), .ValidWay(ValidWay), .LockWay(LockWay), .RandIn(RandIn),
    .FillDone(FillDone), .VictimWay(VictimWay), .VictimValid(VictimValid),
    .NoVictim(NoVictim), .LFSRAdvance(LFSRAdvance)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] v, input logic [3:0] l, input logic [7:0] r,
                       input logic [3:0] exp_way, input logic exp_nv);
    ValidWay = v; LockWay = l; RandIn = r; AllocReq = 1'b1;
    exp_q.push_back({exp_nv, exp_way});
    step();
    AllocReq = 1'b0;
  endtask

  task automatic fill(input logic exp_adv);
    FillDone = 1'b1;
    rel_q.push_back(exp_adv);
    step();
    FillDone = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (VictimWay !== 4'b0 || VictimValid !== 1'b0 || NoVictim !== 1'b0 || LFSRAdvance !== 1'b0) begin
      bad++;
      $display("FAIL %s: way=%b valid=%b nv=%b adv=%b, required all zero",
               name, VictimWay, VictimValid, NoVictim, LFSRAdvance);
    end
  endtask

  // Monitor: checks invariants every cycle and pops scoreboard entries on valid edges.
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_adv   = 1'b0;
    logic [3:0] held       = 4'b0;
    logic [4:0] e;
    logic       ea;
    @(posedge clk);
    forever begin
      @(negedge clk);
      total++;
      if (LFSRAdvance && prev_adv) begin
        bad++;
        $display("FAIL adv_double: LFSRAdvance high two cycles, required single pulse");
      end
      total++;
      if (!$onehot0(VictimWay) || (VictimWay == 4'b0 && VictimValid && !NoVictim)) begin
        bad++;
        $display("FAIL way_shape: way=%b valid=%b nv=%b, required one-hot or allowed zero",
                 VictimWay, VictimValid, NoVictim);
      end
      if (sb_on) begin
        if (VictimValid && !prev_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL alloc_unexpected: way=%b nv=%b, required no allocation", VictimWay, NoVictim);
          end else begin
            e = exp_q.pop_front();
            if ({NoVictim, VictimWay} !== e) begin
              bad++;
              $display("FAIL alloc_victim: nv/way=%b/%b, required %b/%b", NoVictim, VictimWay, e[4], e[3:0]);
            end
          end
          held = VictimWay;
        end else if (VictimValid && prev_valid) begin
          total++;
          if (VictimWay !== held) begin
            bad++;
            $display("FAIL hold_stable: way=%b, required %b", VictimWay, held);
          end
        end
        if (!VictimValid && prev_valid) begin
          total++;
          if (rel_q.size() == 0) begin
            bad++;
            $display("FAIL release_unexpected: valid dropped with no release issued");
          end else begin
            ea = rel_q.pop_front();
            if (LFSRAdvance !== ea) begin
              bad++;
              $display("FAIL release_adv: LFSRAdvance=%b, required %b", LFSRAdvance, ea);
            end
          end
        end else if (LFSRAdvance) begin
          total++;
          bad++;
          $display("FAIL adv_unexpected: LFSRAdvance=1, required 0");
        end
      end
      prev_valid = VictimValid;
      prev_adv   = LFSRAdvance;
    end
  end

  initial begin
    reset = 1'b1; FlushStage = 1'b0; CacheEn = 1'b1; AllocReq = 1'b0; FillDone = 1'b0;
    ValidWay = 4'b0; LockWay = 4'b0; RandIn = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    check_idle("reset_state");
    step();

    // invalid way first
    alloc(4'b1011, 4'b0000, 8'h03, 4'b0100, 1'b0); step(); fill(1'b0); step();
    // random with lock skip and wrap
    alloc(4'b1111, 4'b1000, 8'h07, 4'b0001, 1'b0); step(); fill(1'b1); step();
    // all ways locked
    alloc(4'b1111, 4'b1111, 8'h00, 4'b0000, 1'b1); step(); fill(1'b0); step();
    // random: start 2 locked, next way 3
    alloc(4'b1111, 4'b0101, 8'h06, 4'b1000, 1'b0); fill(1'b1); step();
    // no free way (invalid one is locked): start 1 locked, take 2
    alloc(4'b1101, 4'b0010, 8'h05, 4'b0100, 1'b0); fill(1'b1); step();
    // lowest invalid way 0 even with several free
    alloc(4'b0010, 4'b0000, 8'h02, 4'b0001, 1'b0); fill(1'b0); step();
    // upper RandIn bits ignored: start 0 locked, take 1
    alloc(4'b1111, 4'b0001, 8'hFC, 4'b0010, 1'b0); fill(1'b1); step();

    // flush beats FillDone, then fresh allocation
    alloc(4'b1111, 4'b0000, 8'h00, 4'b0001, 1'b0); step();
    FlushStage = 1'b1; FillDone = 1'b1; rel_q.push_back(1'b0);
    step();
    FlushStage = 1'b0; FillDone = 1'b0;
    check_idle("flush_clear");
    alloc(4'b1111, 4'b0000, 8'h02, 4'b0100, 1'b0); fill(1'b1); step();

    // reset mid-HOLD one cycle before FillDone
    alloc(4'b1111, 4'b0000, 8'h01, 4'b0010, 1'b0); step();
    reset = 1'b1; rel_q.push_back(1'b0);
    step();
    reset = 1'b0;
    check_idle("reset_mid_hold");
    FillDone = 1'b1; step(); FillDone = 1'b0; step();
    // reset coincident with FillDone
    alloc(4'b1111, 4'b0000, 8'h01, 4'b0010, 1'b0);
    reset = 1'b1; FillDone = 1'b1; rel_q.push_back(1'b0);
    step();
    reset = 1'b0; FillDone = 1'b0;
    check_idle("reset_with_fill");
    step();

    // cache disabled
    CacheEn = 1'b0; AllocReq = 1'b1;
    repeat (2) begin
      step();
      total++;
      if (VictimValid !== 1'b0) begin
        bad++;
        $display("FAIL cache_disabled: VictimValid=%b, required 0", VictimValid);
      end
    end
    AllocReq = 1'b0; CacheEn = 1'b1; step();

    // hold stability under input churn; AllocReq at the exit edge must be ignored
    alloc(4'b0111, 4'b0001, 8'h00, 4'b1000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      AllocReq = 1'b1;
      ValidWay = 4'($urandom); LockWay = 4'($urandom); RandIn = 8'($urandom);
      step();
    end
    fill(1'b0);
    AllocReq = 1'b0;
    repeat (2) step();

    total++;
    if (exp_q.size() != 0 || rel_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending alloc=%0d release=%0d, required 0/0", exp_q.size(), rel_q.size());
    end

    // random regression: invariants only
    sb_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      AllocReq   = ($urandom_range(0, 2) != 0);
      FillDone   = ($urandom_range(0, 2) == 0);
      FlushStage = ($urandom_range(0, 9) == 0);
      CacheEn    = ($urandom_range(0, 7) != 0);
      reset      = ($urandom_range(0, 49) == 0);
      ValidWay   = 4'($urandom); LockWay = 4'($urandom); RandIn = 8'($urandom);
      step();
    end
    reset = 1'b1; AllocReq = 1'b0; FillDone = 1'b0; FlushStage = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/random_victim_sel.md
RANDOM_VICTIM_SEL -- requirements
Module: random_victim_sel

Interface
REQ-001 SHALL have parameter NUMWAYS, default 4, meaning the number of cache ways; power of 2 in the range 2..16.
REQ-002 SHALL have parameter LFSRWIDTH, default 8, meaning the width of the random input; LFSRWIDTH SHALL be >= log2(NUMWAYS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port FlushStage, input, 1 bit: pipeline flush; aborts any allocation in progress.
REQ-006 SHALL have port CacheEn, input, 1 bit: cache enabled; when low, new allocation requests are ignored.
REQ-007 SHALL have port AllocReq, input, 1 bit: a miss needs a victim way.
REQ-008 SHALL have port ValidWay, input, NUMWAYS bits: valid bits of the addressed set, sampled with AllocReq.
REQ-009 SHALL have port LockWay, input, NUMWAYS bits: ways excluded from replacement, sampled with AllocReq.
REQ-010 SHALL have port RandIn, input, LFSRWIDTH bits: current pseudo-random value from the upstream LFSR.
REQ-011 SHALL have port FillDone, input, 1 bit: the line fill into the victim way is complete.
REQ-012 SHALL have port VictimWay, output, NUMWAYS bits: one-hot selected way.
REQ-013 SHALL have port VictimValid, output, 1 bit: VictimWay is held and usable.
REQ-014 SHALL have port NoVictim, output, 1 bit: every way was locked at selection time.
REQ-015 SHALL have port LFSRAdvance, output, 1 bit: one-cycle strobe wired to the LFSR write enable.

Function
REQ-016 SHALL implement the states IDLE and HOLD.
REQ-017 IDLE -> HOLD SHALL occur on AllocReq & CacheEn & ~FlushStage; the victim is registered on that edge, so VictimValid=1 in the following cycle (latency 1).
REQ-018 Victim choice, step 1: SHALL select the lowest-index way with ~ValidWay & ~LockWay.
REQ-019 Victim choice, step 2: if no such way exists, SHALL compute start = RandIn[log2(NUMWAYS)-1:0] and select the first way with ~LockWay, searching upward from start and wrapping modulo NUMWAYS.
REQ-020 Victim choice, step 3: if LockWay is all ones, SHALL set VictimWay=0 (all bits clear) and NoVictim=1, with VictimValid=1, and still enter HOLD.
REQ-021 In HOLD, VictimWay and NoVictim SHALL remain stable; AllocReq, ValidWay, LockWay and RandIn SHALL be ignored.
REQ-022 HOLD -> IDLE on FillDone & ~FlushStage: LFSRAdvance SHALL be 1 in the cycle following FillDone, and VictimValid SHALL be 0 in that same cycle.
REQ-023 LFSRAdvance SHALL assert only when the victim came from step 2, not from step 1 or step 3, so the LFSR steps once per random replacement.
REQ-024 HOLD -> IDLE on FlushStage, regardless of FillDone: LFSRAdvance SHALL stay 0; VictimWay, VictimValid and NoVictim SHALL clear.
REQ-025 In IDLE, FillDone SHALL be ignored.
REQ-026 LFSRAdvance SHALL never be high for two consecutive cycles.
REQ-027 VictimWay SHALL always be one-hot or zero; it SHALL be zero only when VictimValid=0 or NoVictim=1.
REQ-028 An AllocReq in the same cycle as the HOLD->IDLE transition SHALL be ignored; the next allocation needs AllocReq while in IDLE.

Reset
REQ-029 When reset is high at a clock edge, the block SHALL enter IDLE, with VictimWay=0, VictimValid=0, NoVictim=0 and LFSRAdvance=0.
REQ-030 Reset SHALL override every other input, including reset asserted mid-HOLD or coincident with FillDone, and SHALL produce no LFSRAdvance pulse.

Verification
REQ-031 Invalid way first: NUMWAYS=4, ValidWay=1011, LockWay=0000, RandIn=0x03, AllocReq -> next cycle VictimWay=0100, VictimValid=1; after FillDone, LFSRAdvance stays 0.
REQ-032 Random pick with lock skip: ValidWay=1111, LockWay=1000, RandIn=0x07 (start=3) -> VictimWay=0001 (wrap); FillDone -> LFSRAdvance=1 for exactly one cycle.
REQ-033 All ways locked: ValidWay=1111, LockWay=1111, AllocReq -> VictimWay=0000, NoVictim=1, VictimValid=1; FillDone -> IDLE with no LFSRAdvance.
REQ-034 Flush priority: in HOLD, drive FlushStage=1 and FillDone=1 together -> next cycle VictimValid=0, LFSRAdvance=0; a new AllocReq with RandIn=0x02 and ValidWay=1111 -> VictimWay=0100.
REQ-035 Reset mid-operation: assert reset in HOLD one cycle before FillDone -> all outputs 0 and no LFSRAdvance pulse; with CacheEn=0, AllocReq keeps VictimValid=0.
REQ-036 Hold stability: in HOLD, change RandIn, ValidWay and LockWay and pulse AllocReq for 10 cycles -> VictimWay unchanged; a random regression checks REQ-026 and REQ-027 every cycle.
